ram_burst_reader: RTL and testbench

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_pkg.sv | 19 +
 rtl/rd_sync_fifo.sv | 57 +++++
 rtl/ram_burst_reader.sv | 133 +++++++++++++
 tb/tb_ram_burst_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared defaults and FSM encoding for the RAM burst reader.
// Also holds the counter width helper used by the FIFO.
package ram_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 6;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rd_sync_fifo.sv
// Small synchronous FIFO with occupancy count.
// The head word is read combinationally from storage.
module rd_sync_fifo
    import ram_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = DEF_DATA_W,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);

    // Storage, pointers and count; push+pop together keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// Reads a burst of words from a registered-output RAM into a
// stream, throttling issue so the output FIFO never overflows.
module ram_burst_reader
    import ram_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_read_addr,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int CNT_W = cnt_w(FIFO_DEPTH);
    localparam int OCC_W = CNT_W + 1;
    localparam int LEN_W = ADDR_W + 1;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued_q;
    logic [LEN_W-1:0] popped_q;
    logic             tag0;
    logic             tag1;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             pop;
    logic             issue_run;
    logic             last_pop;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] limit;

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;

    // Occupancy counts words in flight; a pop this cycle frees a slot.
    assign occ   = {1'b0, fifo_count} + OCC_W'(tag0) + OCC_W'(tag1);
    assign limit = OCC_W'(FIFO_DEPTH) + OCC_W'(pop);

    assign issue_run = (state == RUN) && (issued_q < len_q)
                       && (occ < limit);
    assign last_pop  = pop && ((popped_q + LEN_W'(1)) == len_q);

    // Burst control FSM; first address issues on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            len_q         <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            ram_read_addr <= '0;
            tag0          <= 1'b0;
        end else begin
            tag0 <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= length;
                        popped_q <= '0;
                        issued_q <= '0;
                        if (length != '0) begin
                            state         <= RUN;
                            busy          <= 1'b1;
                            ram_read_addr <= base_addr;
                            issued_q      <= LEN_W'(1);
                            tag0          <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue_run) begin
                        ram_read_addr <= ram_read_addr + ADDR_W'(1);
                        issued_q      <= issued_q + LEN_W'(1);
                        tag0          <= 1'b1;
                    end
                    if (pop) begin
                        popped_q <= popped_q + LEN_W'(1);
                    end
                    if (last_pop) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Second tag stage lines up with registered RAM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag1 <= 1'b0;
        end else begin
            tag1 <= tag0;
        end
    end

    rd_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag1),
        .push_data (ram_data_out),
        .pop       (pop),
        .pop_data  (m_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader with a preloaded registered RAM model.
// Expected words are queued at start and compared on handshakes.
module tb_ram_burst_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] base_addr;
    logic [6:0] length;
    logic       busy;
    logic       done;
    logic [5:0] ram_read_addr;
    logic [7:0] ram_data_out;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    logic [7:0] mem [64];
    logic [7:0] exp_q [$];

    int n_tests;
    int n_fail;
    int cyc;
    int start_cyc;
    int first_cyc;
    int last_hs_cyc;
    int done_cyc;
    int hs_cnt;
    int max_cnt;
    bit busy_seen;
    bit valid_seen;
    bit stall_q;
    logic [7:0] stall_data;

    ram_burst_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .ram_read_addr (ram_read_addr),
        .ram_data_out  (ram_data_out),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ram_data_out <= mem[ram_read_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        if (busy) busy_seen = 1'b1;
        if (m_valid) valid_seen = 1'b1;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
        if (stall_q) chk("stable", {23'd0, m_valid, m_data}, {23'd0, 1'b1, stall_data});
        if (m_valid && m_ready) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_hs_cyc = cyc;
            hs_cnt++;
            if (exp_q.size() == 0) begin
                chk("extra", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("data", 32'(m_data), 32'(e));
            end
        end
        stall_q    = m_valid && !m_ready;
        stall_data = m_data;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int mode, input int n);
        return (mode == 0) ? 1'b1 : (n % 3 == 0);
    endfunction

    task automatic run_burst(input int base, input int len, input int mode,
                             input bit poke);
        int n;
        first_cyc   = -1;
        done_cyc    = -1;
        last_hs_cyc = -1;
        hs_cnt      = 0;
        max_cnt     = 0;
        busy_seen   = 1'b0;
        valid_seen  = 1'b0;
        stall_q     = 1'b0;
        for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % 64]);
        start     = 1'b1;
        base_addr = 6'(base);
        length    = 7'(len);
        m_ready   = rdy(mode, 0);
        start_cyc = cyc + 1;
        tick();
        start = 1'b0;
        n = 1;
        while (done_cyc < 0 && n < 400) begin
            m_ready = rdy(mode, n);
            if (poke && n == 2) begin
                start     = 1'b1;
                base_addr = 6'd40;
                length    = 7'd7;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk("timeout", 32'(done_cyc >= 0), 32'd1);
        chk("count", 32'(hs_cnt), 32'(len));
        chk("left", 32'(exp_q.size()), 32'd0);
        tick();
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(m_valid), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        stall_q = 1'b0;
        max_cnt = 0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'hA5;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_addr", 32'(ram_read_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        run_burst(5, 4, 0, 1'b0);
        chk("b5_latency", 32'(first_cyc - start_cyc), 32'd3);
        chk("b5_burst", 32'(last_hs_cyc - first_cyc), 32'd3);
        chk("b5_done", 32'(done_cyc - last_hs_cyc), 32'd1);
        chk("b5_busy", 32'(busy_seen), 32'd1);

        run_burst(62, 4, 0, 1'b0);
        chk("b62_latency", 32'(first_cyc - start_cyc), 32'd3);
        chk("b62_addr", 32'(ram_read_addr), 32'd1);

        run_burst(0, 64, 1, 1'b0);
        chk("b64_fifo_max", 32'(max_cnt <= 4), 32'd1);

        run_burst(0, 64, 0, 1'b0);
        chk("b64f_burst", 32'(last_hs_cyc - first_cyc), 32'd63);

        run_burst(17, 0, 0, 1'b0);
        chk("len0_done", 32'(done_cyc - start_cyc), 32'd1);
        chk("len0_busy", 32'(busy_seen), 32'd0);
        chk("len0_valid", 32'(valid_seen), 32'd0);

        run_burst(30, 6, 1, 1'b1);

        stall_q   = 1'b0;
        start     = 1'b1;
        base_addr = 6'd20;
        length    = 7'd10;
        m_ready   = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(mem[20 + i]);
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_data", 32'(m_data), 32'd0);
        chk("mid_rst_addr", 32'(ram_read_addr), 32'd0);
        exp_q.delete();
        stall_q = 1'b0;
        tick();
        tick();
        rst_n      = 1'b1;
        valid_seen = 1'b0;
        busy_seen  = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("post_rst_valid", 32'(valid_seen), 32'd0);
        chk("post_rst_busy", 32'(busy_seen), 32'd0);

        run_burst(9, 3, 0, 1'b0);
        chk("post_rst_latency", 32'(first_cyc - start_cyc), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
